sap1_alu: RTL
=============

// Module: sap1_alu
// PURPOSE
//   Arithmetic stage directly downstream of the accumulator (register A). Holds register B,
//   consumes A's value, performs ADD/SUB/CMP in one cycle or MUL as an iterative shift-add,
//   registers result and flags, and drives the result onto the shared 8-bit bus on enable.
//   The controller-sequencer starts an operation with start/op and waits for done.
// PARAMETERS
//   WIDTH    8    datapath/bus width in bits
// PORTS
//   clk           in   1      system clock, all state updates on rising edge
//   rst           in   1      asynchronous, active-low reset
//   loadb         in   1      capture data_in_bus into register B at the clock edge
//   data_in_bus   in   WIDTH  shared bus value, source for B
//   a_in          in   WIDTH  current register A contents
//   op            in   2      00 ADD, 01 SUB, 10 MUL, 11 CMP
//   start         in   1      request operation; accepted only when busy=0
//   eu            in   1      drive result onto data_out_bus
//   data_out_bus  out  WIDTH  result when eu=1, else all-Z
//   busy          out  1      operation in progress
//   done          out  1      one-cycle pulse: result/flags valid
//   flag_c        out  1      carry (ADD), no-borrow (SUB/CMP), high-byte nonzero (MUL)
//   flag_z        out  1      result (or CMP difference) == 0
//   flag_v        out  1      signed overflow (ADD/SUB/CMP); 0 for MUL
// BEHAVIOUR
//   - Reset (rst=0, any time, async): B, result, flags, busy, done, FSM -> 0 / IDLE.
//     data_out_bus follows eu (Z when eu=0; drives 0 if eu=1 during reset).
//   - loadb: B <= data_in_bus at the edge; allowed while busy, no effect on the running op.
//   - Start accepted in IDLE: a_in, B, op latched into operand regs at that edge.
//   - FSM: IDLE -> EXEC (ADD/SUB/CMP) -> IDLE; IDLE -> MUL (WIDTH iterations) -> IDLE.
//   - ADD/SUB/CMP: busy high 1 cycle; result/flags and done valid the cycle after accept.
//     SUB/CMP = A + ~B + 1; flag_c = carry-out of that sum (1 means A>=B unsigned).
//     CMP updates flags only; result register unchanged.
//   - MUL: unsigned A*B, one multiplier bit per cycle, LSB first; busy for WIDTH cycles;
//     done on the last; result = low WIDTH bits, flag_c = |high WIDTH bits, flag_v = 0.
//   - All arithmetic modulo 2^WIDTH; flags updated only when done pulses.
//   - start while busy: ignored (no queueing). start and loadb same edge: op uses old B.
//   - done deasserts the next cycle; back-to-back start on done cycle is accepted
//     (FSM already IDLE that cycle).
//   - Reset mid-MUL: op aborted, no done pulse, result/flags cleared.
//   - eu purely combinational to data_out_bus; result is held until next ADD/SUB/MUL done.
// STRUCTURE
//   - Shared package sap1_pkg: op codes (OP_ADD..OP_CMP), FSM state encoding, WIDTH default.
//   - One sub-module: sap1_addsub (combinational WIDTH-bit add/sub with c/v outputs),
//     reused by EXEC state and by MUL partial-sum accumulation.
//   - Top holds register B, operand latches, FSM, MUL counter/shift regs, result/flag regs,
//     tri-state bus driver.
// TESTING
//   1 Reset: rst=0 mid-run -> busy=0, done=0, flags=0; eu=0 -> data_out_bus=8'hZZ.
//   2 ADD: A=8'h0F, loadb B=8'h01, start op=00 -> done next cycle, result=8'h10, c=0,z=0,v=0;
//     A=8'hFF,B=8'h01 -> result=8'h00, c=1, z=1.
//   3 SUB/CMP: A=8'h05,B=8'h07 SUB -> result=8'hFE, c=0; then CMP A=8'h07,B=8'h07
//     -> z=1, c=1, result still 8'hFE; A=8'h80,B=8'h01 SUB -> v=1.
//   4 MUL: A=8'h0C,B=8'h0B -> busy 8 cycles, done, result=8'h84, c=0;
//     A=8'h10,B=8'h10 -> result=8'h00, c=1, z=1.
//   5 Handshake: start again while MUL busy with op=00 -> ignored, MUL result intact;
//     loadb B=8'h22 mid-MUL -> current result unaffected, next ADD uses 8'h22.
//   6 Abort: rst=0 at MUL cycle 4 -> no done pulse, result=0; eu=1 -> bus=8'h00.

Source files
------------

// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 arithmetic stage: operation codes,
// controller FSM encoding and the default datapath width.
package sap1_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_CMP = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2
  } state_t;

endpackage

// File: rtl/sap1_alu_if.sv
// Controller-side bundle for the SAP-1 ALU: operand/bus inputs, start handshake,
// tri-state result bus and status flags.
interface sap1_alu_if
  import sap1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             loadb;
  logic [WIDTH-1:0] data_in_bus;
  logic [WIDTH-1:0] a_in;
  op_t              op;
  logic             start;
  logic             eu;
  wire  [WIDTH-1:0] data_out_bus;
  logic             busy;
  logic             done;
  logic             flag_c;
  logic             flag_z;
  logic             flag_v;

  modport master (
    output loadb, data_in_bus, a_in, op, start, eu,
    input  data_out_bus, busy, done, flag_c, flag_z, flag_v
  );

  modport slave (
    input  loadb, data_in_bus, a_in, op, start, eu,
    output data_out_bus, busy, done, flag_c, flag_z, flag_v
  );

endinterface

// File: rtl/sap1_addsub.sv
// Combinational WIDTH-bit adder/subtractor; subtraction is a + ~b + 1 so that
// c reads as "no borrow" and v flags signed overflow of the effective sum.
module sap1_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             c,
  output logic             v
);

  logic [WIDTH-1:0] b_eff;

  assign b_eff    = b ^ {WIDTH{sub}};
  assign {c, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign v        = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/sap1_alu.sv
// SAP-1 arithmetic stage: register B, single-cycle ADD/SUB/CMP, shift-add MUL,
// registered result/flags and a tri-state driver onto the shared bus.
module sap1_alu
  import sap1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic     clk,
  input  logic     rst,
  sap1_alu_if.slave bus
);

  localparam int             CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] opa_reg, opb_reg;
  op_t              op_reg;
  logic [WIDTH-1:0] acc_reg, mq_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] result_reg;
  logic             c_reg, z_reg, v_reg, done_reg;

  logic             busy, exec_fire, mul_step, mul_last, accept;
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_sub, add_c, add_v;
  logic [WIDTH-1:0] acc_next, mq_next;

  assign accept = (state_reg == ST_IDLE) && bus.start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (bus.start) state_next = (bus.op == OP_MUL) ? ST_MUL : ST_EXEC;
      ST_EXEC: state_next = ST_IDLE;
      ST_MUL:  if (cnt_reg == CNT_LAST) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    exec_fire = 1'b0;
    mul_step  = 1'b0;
    case (state_reg)
      ST_EXEC: begin busy = 1'b1; exec_fire = 1'b1; end
      ST_MUL:  begin busy = 1'b1; mul_step  = 1'b1; end
      default: ;
    endcase
  end

  assign mul_last = mul_step && (cnt_reg == CNT_LAST);

  // During MUL the adder accumulates the multiplicand into the high half
  // whenever the current multiplier LSB is set.
  assign add_a   = mul_step ? acc_reg : opa_reg;
  assign add_b   = mul_step ? (mq_reg[0] ? opa_reg : '0) : opb_reg;
  assign add_sub = !mul_step && (op_reg != OP_ADD);

  sap1_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .sum (add_sum),
    .c   (add_c),
    .v   (add_v)
  );

  // {carry, sum, multiplier} shifted right one place per iteration.
  assign acc_next = {add_c, add_sum[WIDTH-1:1]};
  assign mq_next  = {add_sum[0], mq_reg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) b_reg <= '0;
    else if (bus.loadb) b_reg <= bus.data_in_bus;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opa_reg <= '0;
      opb_reg <= '0;
      op_reg  <= OP_ADD;
      acc_reg <= '0;
      mq_reg  <= '0;
      cnt_reg <= '0;
    end else if (accept) begin
      opa_reg <= bus.a_in;
      opb_reg <= b_reg;
      op_reg  <= bus.op;
      acc_reg <= '0;
      mq_reg  <= b_reg;
      cnt_reg <= '0;
    end else if (mul_step) begin
      acc_reg <= acc_next;
      mq_reg  <= mq_next;
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_reg <= '0;
      c_reg      <= 1'b0;
      z_reg      <= 1'b0;
      v_reg      <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (exec_fire) begin
        if (op_reg != OP_CMP) result_reg <= add_sum;
        c_reg    <= add_c;
        z_reg    <= (add_sum == '0);
        v_reg    <= add_v;
        done_reg <= 1'b1;
      end else if (mul_last) begin
        result_reg <= mq_next;
        c_reg      <= |acc_next;
        z_reg      <= (mq_next == '0);
        v_reg      <= 1'b0;
        done_reg   <= 1'b1;
      end
    end
  end

  assign bus.busy         = busy;
  assign bus.done         = done_reg;
  assign bus.flag_c       = c_reg;
  assign bus.flag_z       = z_reg;
  assign bus.flag_v       = v_reg;
  assign bus.data_out_bus = bus.eu ? result_reg : {WIDTH{1'bz}};

endmodule
